// File: rtl/jtag_pkg.sv
// jtag_pkg
//   Shared types for the JTAG master:
//     tap_ctrl_fsm_t  - the 16 IEEE 1149.1 TAP controller states (mirrored by the master)
//     master_fsm_t    - sequencing states of the master itself
//     tap_next_state  - TAP transition function, evaluated on every TCK rising edge
package jtag_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET,
    RUN_TEST_IDLE,
    SELECT_DR_SCAN,
    CAPTURE_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPDATE_DR,
    SELECT_IR_SCAN,
    CAPTURE_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPDATE_IR
  } tap_ctrl_fsm_t;

  typedef enum logic [1:0] {
    M_INIT,
    M_IDLE,
    M_SCAN,
    M_RSP
  } master_fsm_t;

  function automatic tap_ctrl_fsm_t tap_next_state(input tap_ctrl_fsm_t cur, input logic tms);
    tap_ctrl_fsm_t nxt;
    nxt = TEST_LOGIC_RESET;
    case (cur)
      TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   nxt = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       nxt = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         nxt = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         nxt = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         nxt = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         nxt = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       nxt = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         nxt = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         nxt = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         nxt = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         nxt = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          nxt = TEST_LOGIC_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen
//   Divides clk down to TCK. While en is high TCK toggles every TCK_DIV clk cycles,
//   starting from a full low phase; while en is low TCK is held 0 and the divider restarts.
//   Ports:
//     clk, rst  - system clock, synchronous active-high reset
//     en        - run TCK
//     tck       - registered test clock
//     rise_stb  - high in the clk cycle whose edge drives tck 0->1
//     fall_stb  - high in the clk cycle whose edge drives tck 1->0
module jtag_tck_gen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tck,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TCK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap     = en && (cnt == LAST);
  assign rise_stb = wrap && !tck;
  assign fall_stb = wrap && tck;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/jtag_tap_master.sv
// jtag_tap_master
//   Initiator side of a JTAG link. Takes IR/DR scan commands, walks the external TAP
//   from Run-Test/Idle through Shift-xR and back, shifts cmd_data out LSB first on TDI
//   and returns the TDO bits captured during Shift-xR.
//   Ports:
//     clk, rst                       - system clock, synchronous active-high reset
//     cmd_valid/cmd_ready            - command handshake (ready only while idle)
//     cmd_ir, cmd_len, cmd_data      - scan type, bit count (clamped to MAX_BITS), TDI bits
//     rsp_valid/rsp_ready, rsp_data  - captured TDO bits, first sampled bit in bit0
//     jtag_tck/tms/tdi, jtag_tdo     - JTAG pins
//     tap_state                      - mirror of the external TAP controller state
module jtag_tap_master
  import jtag_pkg::*;
#(
  parameter int MAX_BITS = 64,
  parameter int TCK_DIV  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_ir,
  input  logic [$clog2(MAX_BITS+1)-1:0] cmd_len,
  input  logic [MAX_BITS-1:0]           cmd_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [MAX_BITS-1:0]           rsp_data,
  output logic                          jtag_tck,
  output logic                          jtag_tms,
  output logic                          jtag_tdi,
  input  logic                          jtag_tdo,
  output tap_ctrl_fsm_t                 tap_state
);

  localparam int LW = $clog2(MAX_BITS + 1);
  localparam int SW = $clog2(MAX_BITS + 7);
  localparam int IW = $clog2(MAX_BITS);

  master_fsm_t         state, state_next;
  logic                tck_en, rise_stb, fall_stb;
  logic                accept, in_shift, scan_done, tms_now;
  logic                ir_q;
  logic [LW-1:0]       len_q, shift_cnt, len_clamped;
  logic [SW-1:0]       step, pre_len, shift_end, total;
  logic [IW-1:0]       cap_pos;
  logic [MAX_BITS-1:0] tdi_sr;

  // INIT only starts TCK once TMS has been pulled low, so the single TLR->RTI edge
  // always sees TMS=0 even with TCK_DIV=1.
  assign tck_en = (state == M_SCAN) || ((state == M_INIT) && !jtag_tms);

  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (tck_en),
    .tck      (jtag_tck),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  assign len_clamped = (cmd_len > LW'(MAX_BITS)) ? LW'(MAX_BITS) : cmd_len;
  assign accept      = (state == M_IDLE) && cmd_valid && cmd_ready;
  assign in_shift    = (tap_state == SHIFT_DR) || (tap_state == SHIFT_IR);
  assign cap_pos     = IW'(len_q - shift_cnt);

  // TMS for the rising edge numbered 'step': preamble (DR 1,0,0 / IR 1,1,0,0),
  // len shift edges with TMS=1 only on the last, then 1,0 back to Run-Test/Idle.
  always_comb begin
    pre_len   = ir_q ? SW'(4) : SW'(3);
    shift_end = pre_len + SW'(len_q);
    total     = shift_end + SW'(2);
    tms_now   = 1'b0;
    if (step == '0)
      tms_now = 1'b1;
    else if (step < pre_len)
      tms_now = ir_q && (step == SW'(1));
    else if (step < shift_end)
      tms_now = (step == shift_end - SW'(1));
    else if (step == shift_end)
      tms_now = 1'b1;
  end

  // The scan ends on the falling edge after its last rising edge so TCK idles low.
  assign scan_done = fall_stb && (step == total);

  always_ff @(posedge clk) begin
    if (rst) state <= M_INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      M_INIT: if (fall_stb) state_next = M_IDLE;
      M_IDLE: if (accept) state_next = (len_clamped == '0) ? M_RSP : M_SCAN;
      M_SCAN: if (scan_done) state_next = M_RSP;
      M_RSP:  if (rsp_valid && rsp_ready) state_next = M_IDLE;
      default: state_next = M_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      jtag_tms  <= 1'b1;
      jtag_tdi  <= 1'b0;
      tap_state <= TEST_LOGIC_RESET;
      ir_q      <= 1'b0;
      len_q     <= '0;
      shift_cnt <= '0;
      step      <= '0;
      tdi_sr    <= '0;
    end else begin
      cmd_ready <= (state_next == M_IDLE);
      rsp_valid <= (state_next == M_RSP);

      if (state == M_INIT)
        jtag_tms <= 1'b0;

      // First low phase of a scan: present TMS/TDI for edge 0 right away.
      if (accept) begin
        ir_q      <= cmd_ir;
        len_q     <= len_clamped;
        shift_cnt <= len_clamped;
        step      <= '0;
        tdi_sr    <= cmd_data;
        rsp_data  <= '0;
        jtag_tms  <= (len_clamped != '0);
        jtag_tdi  <= (len_clamped != '0) && cmd_data[0];
      end

      if (rise_stb) begin
        tap_state <= tap_next_state(tap_state, jtag_tms);
        if (state == M_SCAN) begin
          step <= step + SW'(1);
          if (in_shift && (shift_cnt != '0)) begin
            rsp_data[cap_pos] <= jtag_tdo;
            shift_cnt         <= shift_cnt - LW'(1);
            tdi_sr            <= tdi_sr >> 1;
          end
        end
      end

      if (fall_stb && (state == M_SCAN)) begin
        if (scan_done) begin
          jtag_tms <= 1'b0;
          jtag_tdi <= 1'b0;
        end else begin
          jtag_tms <= tms_now;
          jtag_tdi <= tdi_sr[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_master.sv
// tb_jtag_tap_master
//   Table-driven scans against a TDO source that is either a TDI loopback or a constant,
//   with a scoreboard queue of expected responses, plus hand-written sequences for reset,
//   response back-pressure and reset in the middle of a shift.
module tb_jtag_tap_master;
  import jtag_pkg::*;

  localparam int MAX_BITS = 64;
  localparam int TCK_DIV  = 4;
  localparam int LW       = $clog2(MAX_BITS + 1);

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid, cmd_ready, cmd_ir;
  logic [LW-1:0]       cmd_len;
  logic [MAX_BITS-1:0] cmd_data;
  logic                rsp_valid, rsp_ready;
  logic [MAX_BITS-1:0] rsp_data;
  logic                jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;
  tap_ctrl_fsm_t       tap_state;

  int tdo_mode = 0;   // 0 = loopback TDI, 1 = constant 1, 2 = constant 0
  assign jtag_tdo = (tdo_mode == 0) ? jtag_tdi : (tdo_mode == 1);

  jtag_tap_master #(.MAX_BITS(MAX_BITS), .TCK_DIV(TCK_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ir    (cmd_ir),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .jtag_tck  (jtag_tck),
    .jtag_tms  (jtag_tms),
    .jtag_tdi  (jtag_tdi),
    .jtag_tdo  (jtag_tdo),
    .tap_state (tap_state)
  );

  always #5 clk = ~clk;

  int                  total_checks = 0;
  int                  bad_checks   = 0;
  logic [MAX_BITS-1:0] exp_q[$];
  int                  rise_cnt = 0;
  logic                tms_q[$];
  bit                  shift_ir_seen = 0;

  always @(posedge jtag_tck) begin
    rise_cnt = rise_cnt + 1;
    tms_q.push_back(jtag_tms);
  end

  always @(negedge clk) begin
    if (tap_state == SHIFT_IR) shift_ir_seen = 1;
  end

  typedef struct {
    logic        ir;
    int          len;
    logic [63:0] data;
    int          mode;
    int          rises;
    logic [63:0] rsp;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_checks++;
    if (act !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic exp_tms(input logic ir, input int len, input int i);
    int pre;
    pre = ir ? 4 : 3;
    if (i < pre) return (i == 0) || (ir && i == 1);
    if (i < pre + len) return (i == pre + len - 1);
    return (i == pre + len);
  endfunction

  task automatic waitReady(input string name);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) checkOutput({name, "_ready_timeout"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic applyStimulus(input logic ir, input int len, input logic [63:0] data,
                               input int mode, input logic [63:0] exp_rsp);
    waitReady("stim");
    @(negedge clk);
    tdo_mode  = mode;
    cmd_ir    = ir;
    cmd_len   = LW'(len);
    cmd_data  = data;
    cmd_valid = 1'b1;
    rise_cnt  = 0;
    tms_q.delete();
    shift_ir_seen = 0;
    exp_q.push_back(exp_rsp);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic popCompare(input string name);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      checkOutput({name, "_scoreboard_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      checkOutput({name, "_rsp_data"}, rsp_data, e);
    end
  endtask

  task automatic waitRsp(input string name, output bit ok);
    int n;
    n = 0;
    while (!rsp_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = rsp_valid;
    if (!ok) checkOutput({name, "_rsp_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic collectResponse(input string name, input logic ir, input int len_eff,
                                 input int exp_rises);
    bit ok;
    int bad_tms;
    waitRsp(name, ok);
    if (ok) begin
      popCompare(name);
      checkOutput({name, "_rises"}, 64'(rise_cnt), 64'(exp_rises));
      bad_tms = 0;
      for (int i = 0; i < tms_q.size() && i < exp_rises; i++)
        if (tms_q[i] !== exp_tms(ir, len_eff, i)) bad_tms++;
      checkOutput({name, "_tms_seq_errors"}, 64'(bad_tms), 64'd0);
      checkOutput({name, "_tap_state"}, 64'(tap_state), 64'(RUN_TEST_IDLE));
      checkOutput({name, "_shift_ir_seen"}, 64'(shift_ir_seen), 64'(ir && len_eff > 0));
      checkOutput({name, "_tck_idle"}, 64'(jtag_tck), 64'd0);
      checkOutput({name, "_ready_in_rsp"}, 64'(cmd_ready), 64'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checkOutput({name, "_ready_after"}, 64'(cmd_ready), 64'd1);
      checkOutput({name, "_valid_after"}, 64'(rsp_valid), 64'd0);
    end
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    int viol;
    int n;
    string nm;

    vecs[0] = '{1'b0,  8, 64'hA5,               0, 13, 64'hA5};
    vecs[1] = '{1'b1,  5, 64'h11,               1, 11, 64'h1F};
    vecs[2] = '{1'b0,  0, 64'hDEAD,             0,  0, 64'h0};
    vecs[3] = '{1'b0, 70, 64'h0123456789ABCDEF, 0, 69, 64'h0123456789ABCDEF};
    vecs[4] = '{1'b0,  1, 64'h1,                0,  6, 64'h1};
    vecs[5] = '{1'b1,  3, 64'h5,                2,  9, 64'h0};
    vecs[6] = '{1'b0,  4, 64'hFF,               0,  9, 64'hF};
    vecs[7] = '{1'b1,  7, 64'h2A,               0, 13, 64'h2A};

    rst = 1'b1; cmd_valid = 1'b0; cmd_ir = 1'b0; cmd_len = '0; cmd_data = '0; rsp_ready = 1'b0;

    // Reset values, then the single INIT edge into Run-Test/Idle.
    repeat (3) @(negedge clk);
    checkOutput("reset_tck", 64'(jtag_tck), 64'd0);
    checkOutput("reset_tms", 64'(jtag_tms), 64'd1);
    checkOutput("reset_tdi", 64'(jtag_tdi), 64'd0);
    checkOutput("reset_ready", 64'(cmd_ready), 64'd0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_tap", 64'(tap_state), 64'(TEST_LOGIC_RESET));
    rise_cnt = 0;
    tms_q.delete();
    rst = 1'b0;
    n = 0;
    while (!cmd_ready && n < 2 * TCK_DIV + 3) begin
      @(negedge clk);
      n++;
    end
    checkOutput("init_ready", 64'(cmd_ready), 64'd1);
    checkOutput("init_tap", 64'(tap_state), 64'(RUN_TEST_IDLE));
    checkOutput("init_rises", 64'(rise_cnt), 64'd1);
    checkOutput("init_tms_on_edge", 64'(tms_q.size() > 0 ? tms_q[0] : 1'b1), 64'd0);

    // Table-driven scans.
    for (int i = 0; i < 8; i++) begin
      nm = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].ir, vecs[i].len, vecs[i].data, vecs[i].mode, vecs[i].rsp);
      if (vecs[i].len == 0)
        checkOutput({nm, "_len0_rsp_next_clk"}, 64'(rsp_valid), 64'd1);
      collectResponse(nm, vecs[i].ir, (vecs[i].len > MAX_BITS) ? MAX_BITS : vecs[i].len,
                      vecs[i].rises);
    end

    // Back-pressure: response held 20 clk while a zero-length command waits.
    applyStimulus(1'b0, 8, 64'h3C, 0, 64'h3C);
    waitRsp("hold", ok);
    if (ok) begin
      cmd_valid = 1'b1; cmd_ir = 1'b0; cmd_len = '0; cmd_data = 64'h77;
      viol = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (jtag_tck !== 1'b0 || cmd_ready !== 1'b0 || rsp_valid !== 1'b1 ||
            rsp_data !== 64'h3C)
          viol++;
      end
      checkOutput("hold_violations", 64'(viol), 64'd0);
      popCompare("hold");
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checkOutput("hold_release_ready", 64'(cmd_ready), 64'd1);
      checkOutput("hold_release_valid", 64'(rsp_valid), 64'd0);
      exp_q.push_back(64'h0);
      @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput("hold_len0_valid", 64'(rsp_valid), 64'd1);
      popCompare("hold_len0");
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end

    // Reset in the middle of a DR shift, then a clean scan afterwards.
    applyStimulus(1'b0, 16, 64'h1234, 0, 64'h1234);
    n = 0;
    while (tap_state != SHIFT_DR && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrst_reached_shift", 64'(tap_state), 64'(SHIFT_DR));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_tck", 64'(jtag_tck), 64'd0);
    checkOutput("midrst_tms", 64'(jtag_tms), 64'd1);
    checkOutput("midrst_tdi", 64'(jtag_tdi), 64'd0);
    checkOutput("midrst_ready", 64'(cmd_ready), 64'd0);
    checkOutput("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("midrst_rsp_data", rsp_data, 64'd0);
    checkOutput("midrst_tap", 64'(tap_state), 64'(TEST_LOGIC_RESET));
    exp_q.delete();
    rst = 1'b0;
    applyStimulus(1'b0, 4, 64'h9, 0, 64'h9);
    collectResponse("post_rst", 1'b0, 4, 9);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
